// File: rtl/median_pkg.sv
// Shared types for the 3x3 median window controller: FSM states, pixel type, window size.
package median_pkg;
  localparam int WIN_SIZE = 9;

  typedef logic [7:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    SORT,
    WAIT,
    OUT
  } state_t;
endpackage

// File: rtl/median_linebuf.sv
// Single-port IMG_W x 8 delay line: read-before-write at the same address gives one line of delay.
module median_linebuf
  import median_pkg::*;
#(
  parameter int IMG_W = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  pixel_t                   din,
  output pixel_t                   dout
);

  pixel_t mem [IMG_W];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/median_window_ctrl.sv
// 3x3 median window controller: builds raster windows, hands them to an external sorter, returns medians.
// Optional MEDIAN_PERF_EN adds a saturating output-stall counter (stall_cnt).
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int SORT_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   s_valid,
  output logic   s_ready,
  input  pixel_t s_data,
  input  logic   s_sof,
  output logic   sort_en,
  output pixel_t sort_window [WIN_SIZE],
  input  pixel_t sort_median,
  output logic   m_valid,
  input  logic   m_ready,
`ifdef MEDIAN_PERF_EN
  output logic [15:0] stall_cnt,
`endif
  output pixel_t m_data
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LW = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LW-1:0] wcnt;
  logic          last_px;
  pixel_t        win_p0 [WIN_SIZE];
  pixel_t        lb0_q, lb1_q;
  logic          hs, take;
  logic [CW-1:0] lb_addr;

  // Ready is tied to the state so only one window can ever be in flight.
  assign s_ready = !rst && (state == IDLE || state == ACCEPT);
  assign hs      = s_valid && s_ready;
  assign take    = hs && (state == ACCEPT || s_sof);
  assign lb_addr = s_sof ? '0 : col;

  median_linebuf #(.IMG_W(IMG_W)) u_lb0 (
    .clk (clk),
    .we  (take),
    .addr(lb_addr),
    .din (s_data),
    .dout(lb0_q)
  );

  median_linebuf #(.IMG_W(IMG_W)) u_lb1 (
    .clk (clk),
    .we  (take),
    .addr(lb_addr),
    .din (lb0_q),
    .dout(lb1_q)
  );

  // Stage p0: window shifts left, new column {row-2, row-1, row} enters on the right.
  always_ff @(posedge clk) begin
    if (take) begin
      win_p0[0] <= win_p0[1];
      win_p0[1] <= win_p0[2];
      win_p0[2] <= lb1_q;
      win_p0[3] <= win_p0[4];
      win_p0[4] <= win_p0[5];
      win_p0[5] <= lb0_q;
      win_p0[6] <= win_p0[7];
      win_p0[7] <= win_p0[8];
      win_p0[8] <= s_data;
    end
  end

  assign sort_window = win_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      wcnt    <= '0;
      last_px <= 1'b0;
      sort_en <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs && s_sof) begin
            row     <= '0;
            col     <= CW'(1);
            last_px <= 1'b0;
            state   <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (hs && s_sof) begin
            row     <= '0;
            col     <= CW'(1);
            last_px <= 1'b0;
          end else if (hs) begin
            if (row == RW'(IMG_H - 1) && col == CW'(IMG_W - 1)) begin
              row     <= '0;
              col     <= '0;
              last_px <= 1'b1;
            end else if (col == CW'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (row >= RW'(2) && col >= CW'(2)) begin
              sort_en <= 1'b1;
              state   <= SORT;
            end
          end
        end
        SORT: begin
          sort_en <= 1'b0;
          wcnt    <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (wcnt == LW'(SORT_LAT - 1)) begin
            wcnt    <= '0;
            m_data  <= sort_median;
            m_valid <= 1'b1;
            state   <= OUT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= last_px ? IDLE : ACCEPT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEDIAN_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || (hs && s_sof)) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl: a 4x4 instance for frame/stall/restart/reset cases, a 5x5 ramp instance.
module tb_median_window_ctrl;
  import median_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   s_valid4, s_ready4, s_sof4, sort_en4, m_valid4, m_ready4;
  pixel_t s_data4, sort_median4, m_data4;
  pixel_t sort_window4 [WIN_SIZE];
  logic   s_valid5, s_ready5, s_sof5, sort_en5, m_valid5, m_ready5;
  pixel_t s_data5, sort_median5, m_data5;
  pixel_t sort_window5 [WIN_SIZE];
`ifdef MEDIAN_PERF_EN
  logic [15:0] stall_cnt4, stall_cnt5;
`endif

  int nchk = 0;
  int nerr = 0;
  int se4 = 0;
  int se5 = 0;
  pixel_t q4[$];
  pixel_t q5[$];

  always #5 clk = ~clk;

  median_window_ctrl #(.IMG_W(4), .IMG_H(4), .SORT_LAT(1)) u4 (
    .clk(clk), .rst(rst), .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4), .s_sof(s_sof4),
    .sort_en(sort_en4), .sort_window(sort_window4), .sort_median(sort_median4),
    .m_valid(m_valid4), .m_ready(m_ready4),
`ifdef MEDIAN_PERF_EN
    .stall_cnt(stall_cnt4),
`endif
    .m_data(m_data4)
  );

  median_window_ctrl #(.IMG_W(5), .IMG_H(5), .SORT_LAT(1)) u5 (
    .clk(clk), .rst(rst), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5), .s_sof(s_sof5),
    .sort_en(sort_en5), .sort_window(sort_window5), .sort_median(sort_median5),
    .m_valid(m_valid5), .m_ready(m_ready5),
`ifdef MEDIAN_PERF_EN
    .stall_cnt(stall_cnt5),
`endif
    .m_data(m_data5)
  );

  // External sorter stand-in: one-cycle latency median of nine.
  function automatic pixel_t med9(input pixel_t w [WIN_SIZE]);
    pixel_t a [WIN_SIZE];
    pixel_t t;
    a = w;
    for (int i = 0; i < WIN_SIZE; i++)
      for (int j = 0; j < WIN_SIZE - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  always @(posedge clk) begin
    if (sort_en4) sort_median4 <= med9(sort_window4);
    if (sort_en5) sort_median5 <= med9(sort_window5);
  end

  always @(negedge clk) begin
    if (m_valid4 && m_ready4) q4.push_back(m_data4);
    if (m_valid5 && m_ready5) q5.push_back(m_data5);
    if (sort_en4) se4++;
    if (sort_en5) se5++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send4(input pixel_t d, input logic sof);
    int n = 0;
    s_valid4 = 1'b1; s_data4 = d; s_sof4 = sof;
    while (!s_ready4) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("send4_timeout", 1, 0);
        break;
      end
    end
    @(negedge clk);
    s_valid4 = 1'b0; s_sof4 = 1'b0;
  endtask

  task automatic send5(input pixel_t d, input logic sof);
    int n = 0;
    s_valid5 = 1'b1; s_data5 = d; s_sof5 = sof;
    while (!s_ready5) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("send5_timeout", 1, 0);
        break;
      end
    end
    @(negedge clk);
    s_valid5 = 1'b0; s_sof5 = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    pixel_t held;
    pixel_t exp4 [4];
    pixel_t exp5 [9];
    rst = 1'b1;
    s_valid4 = 0; s_data4 = 0; s_sof4 = 0; m_ready4 = 1;
    s_valid5 = 0; s_data5 = 0; s_sof5 = 0; m_ready5 = 1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", int'(s_ready4), 0);
    check("rst_sort_en", int'(sort_en4), 0);
    check("rst_m_valid", int'(m_valid4), 0);
    check("rst_m_data", int'(m_data4), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", int'(s_ready4), 1);
`ifdef MEDIAN_PERF_EN
    check("rst_stall_cnt", int'(stall_cnt4), 0);
`endif

    // Constant 50 frame: four outputs, one sort_en pulse each.
    q4.delete(); base = se4;
    for (int k = 0; k < 16; k++) send4(8'd50, k == 0);
    repeat (10) @(negedge clk);
    check("const_count", q4.size(), 4);
    for (int i = 0; i < 4; i++) check("const_value", int'(q4[i]), 50);
    check("const_sort_en", se4 - base, 4);

    // Single 255 impulse at (1,1) is rejected by every window.
    q4.delete();
    for (int k = 0; k < 16; k++) send4((k == 5) ? 8'd255 : 8'd0, k == 0);
    repeat (10) @(negedge clk);
    check("impulse_count", q4.size(), 4);
    for (int i = 0; i < 4; i++) check("impulse_value", int'(q4[i]), 0);

    // Ramp 0..15 with a 10-cycle downstream stall on the first output.
    q4.delete(); m_ready4 = 1'b0;
    for (int k = 0; k < 11; k++) send4(pixel_t'(k), k == 0);
    n = 0;
    while (!m_valid4 && n < 50) begin @(negedge clk); n++; end
    check("stall_reach_out", int'(m_valid4), 1);
    held = m_data4;
    check("stall_first_value", int'(held), 5);
    for (int i = 0; i < 10; i++) begin
      check("stall_m_data", int'(m_data4), int'(held));
      check("stall_s_ready", int'(s_ready4), 0);
      @(negedge clk);
    end
`ifdef MEDIAN_PERF_EN
    check("stall_cnt", int'(stall_cnt4), 10);
`endif
    m_ready4 = 1'b1;
    for (int k = 11; k < 16; k++) send4(pixel_t'(k), 1'b0);
    repeat (10) @(negedge clk);
    exp4 = '{8'd5, 8'd6, 8'd9, 8'd10};
    check("stall_count", q4.size(), 4);
    for (int i = 0; i < 4; i++) check("stall_frame_value", int'(q4[i]), int'(exp4[i]));

    // Frame restarted by s_sof at pixel (2,1); outputs come only from the fresh frame.
    q4.delete(); base = se4;
    for (int k = 0; k < 9; k++) send4(8'd200, k == 0);
    for (int k = 0; k < 16; k++) send4(pixel_t'(k), k == 0);
    repeat (10) @(negedge clk);
    check("restart_count", q4.size(), 4);
    for (int i = 0; i < 4; i++) check("restart_value", int'(q4[i]), int'(exp4[i]));
    check("restart_sort_en", se4 - base, 4);
`ifdef MEDIAN_PERF_EN
    check("restart_stall_cnt", int'(stall_cnt4), 0);
`endif

    // Reset while waiting on the sorter drops the window.
    q4.delete();
    for (int k = 0; k < 11; k++) send4(pixel_t'(k), k == 0);
    check("rstw_in_sort", int'(sort_en4), 1);
    @(negedge clk);
    check("rstw_in_wait", int'(u4.state), int'(WAIT));
    rst = 1'b1;
    @(negedge clk);
    check("rstw_sort_en", int'(sort_en4), 0);
    check("rstw_m_valid", int'(m_valid4), 0);
    check("rstw_state", int'(u4.state), int'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    send4(8'd77, 1'b0);
    repeat (5) @(negedge clk);
    check("rstw_discard_state", int'(u4.state), int'(IDLE));
    check("rstw_no_output", q4.size(), 0);

    // 5x5 ramp: each median equals the window centre.
    q5.delete(); base = se5;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) send5(pixel_t'(r * 5 + c), (r == 0) && (c == 0));
    repeat (10) @(negedge clk);
    exp5 = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18};
    check("ramp5_count", q5.size(), 9);
    for (int i = 0; i < 9; i++) check("ramp5_value", int'(q5[i]), int'(exp5[i]));
    check("ramp5_sort_en", se5 - base, 9);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/median_window_ctrl.md
MEDIAN_WINDOW_CTRL -- requirements
Module: median_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 64, meaning pixels per line (min 3).
REQ-002 SHALL have parameter IMG_H, default 64, meaning lines per frame (min 3).
REQ-003 SHALL have parameter SORT_LAT, default 1, meaning cycles from sort_en to a valid sort_median (min 1).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port s_valid, input, 1 bit: input pixel valid.
REQ-007 SHALL have port s_ready, output, 1 bit: controller accepts the input pixel.
REQ-008 SHALL have port s_data, input, 8 bits: input pixel, raster order.
REQ-009 SHALL have port s_sof, input, 1 bit: marks s_data as pixel (0,0) of a frame.
REQ-010 SHALL have port sort_en, output, 1 bit: load strobe to the sorter.
REQ-011 SHALL have port sort_window, output, 9x8 unpacked array: [0..8] is the 3x3 window, row-major, [0] top-left.
REQ-012 SHALL have port sort_median, input, 8 bits: median returned by the sorter.
REQ-013 SHALL have port m_valid, output, 1 bit: filtered pixel valid.
REQ-014 SHALL have port m_ready, input, 1 bit: downstream accepts the filtered pixel.
REQ-015 SHALL have port m_data, output, 8 bits: filtered pixel for window centre (row-1, col-1).

Function
REQ-016 SHALL implement an FSM with states IDLE, ACCEPT, SORT, WAIT and OUT.
REQ-017 IDLE: s_ready=1; a handshake with s_sof=1 stores the pixel as (0,0) and moves to ACCEPT; a handshake with s_sof=0 discards the pixel.
REQ-018 ACCEPT: s_ready=1; on handshake, write the pixel into the line buffers and shift the window, then advance col; at col wrap (col==IMG_W-1) set col=0 and row=row+1.
REQ-019 ACCEPT: after a handshake at row>=2 and col>=2, go to SORT; otherwise stay in ACCEPT, or go to IDLE after pixel (IMG_H-1, IMG_W-1).
REQ-020 SORT: sort_en=1 for exactly one cycle with sort_window stable; s_ready=0; then go to WAIT.
REQ-021 WAIT: count SORT_LAT cycles; on the last count, register sort_median into m_data and go to OUT.
REQ-022 OUT: m_valid=1; m_data is held stable until m_valid and m_ready are both high; then go to ACCEPT, or to IDLE if the frame's last pixel has been consumed.
REQ-023 s_ready SHALL be 0 in SORT, WAIT and OUT, so at most one window is in flight.
REQ-024 Line buffers SHALL be two IMG_W x 8 arrays; window column = {lb1[col], lb0[col], s_data}.
REQ-025 A handshake with s_sof=1 in ACCEPT SHALL restart the frame: row=0, col=0, the pixel is stored as (0,0), and no window is emitted.
REQ-026 Outputs per frame SHALL equal (IMG_W-2)*(IMG_H-2); border pixels produce no output.
REQ-027 sort_en SHALL never be asserted outside SORT; m_valid SHALL never be asserted outside OUT.

Reset
REQ-028 rst SHALL force IDLE, row=0, col=0, wait counter=0, sort_en=0, m_valid=0, m_data=0, s_ready=0 during reset; s_ready returns to 1 the first cycle after reset.
REQ-029 Reset mid-frame SHALL drop any in-flight window; line buffer contents need not be cleared.

Configuration
REQ-030 With MEDIAN_PERF_EN defined, the block SHALL add output stall_cnt, 16 bits, counting cycles with m_valid=1 and m_ready=0; it saturates at 16'hFFFF and is cleared by rst and by a s_sof handshake.
REQ-031 Without MEDIAN_PERF_EN, the port and counter SHALL be absent.

Structure
REQ-032 A shared package median_pkg SHALL hold the FSM state enum, the pixel_t 8-bit typedef and WIN_SIZE=9.
REQ-033 One sub-module, median_linebuf (a single-port IMG_W x 8 delay line), SHALL be instantiated twice; the sorter is external.

Verification
REQ-034 IMG_W=IMG_H=4, constant 8'd50 frame -> exactly 4 outputs, all 50, each preceded by a single sort_en pulse.
REQ-035 4x4 all zeros with 255 at (1,1) -> 4 outputs, all 0.
REQ-036 m_ready held 0 for 10 cycles in OUT -> m_data stable, s_ready=0 throughout; with MEDIAN_PERF_EN, stall_cnt=10.
REQ-037 s_sof reasserted at pixel (2,1) -> counters restart, the next outputs match a fresh frame, no spurious m_valid.
REQ-038 rst asserted in WAIT -> next cycle sort_en=0, m_valid=0, state IDLE; a subsequent non-sof pixel is discarded.
REQ-039 5x5 ramp s_data=row*5+col with m_ready always 1 -> 9 outputs equal to the centre value (row*5+col) of each window.
